// File: rtl/ann_layer.sv
// rtl/ann_layer.sv - M-neuron fixed-point dense layer: serial MAC over N inputs, bias, ReLU/linear, saturate.
// Optional round-half-up before the final shift when ANN_LAYER_ROUND_EN is defined.
module ann_layer #(
   parameter int DW    = 8,
   parameter int N     = 10,
   parameter int M     = 4,
   parameter int FRAC  = 4,
   parameter int ACC_W = 2*DW + $clog2(N) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hidden,
   input  logic [DW*N-1:0]   value,
   input  logic [DW*N*M-1:0] weight,
   input  logic [DW*M-1:0]   bias,
   output logic [DW*M-1:0]   result,
   output logic              busy,
   output logic              done
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef ANN_LAYER_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd1 <<< (FRAC-1));
`endif

   typedef enum logic [1:0] {IDLE, MAC, BIAS, ACT} state_t;

   state_t                   state_q;
   logic [KW-1:0]            k_q;
   logic [DW*N-1:0]          value_q;
   logic [DW*N*M-1:0]        weight_q;
   logic [DW*M-1:0]          bias_q;
   logic                     hidden_q;
   logic signed [ACC_W-1:0]  acc_q [M];
   logic [DW*M-1:0]          result_q;
   logic                     busy_q;
   logic                     done_q;

   logic signed [DW-1:0]     val_k;
   logic signed [DW-1:0]     wgt_k   [M];
   logic signed [2*DW-1:0]   prod    [M];
   logic signed [ACC_W-1:0]  mac_d   [M];
   logic signed [ACC_W-1:0]  bias_d  [M];
   logic signed [ACC_W-1:0]  sum     [M];
   logic signed [ACC_W-1:0]  shr     [M];
   logic [DW*M-1:0]          result_d;

   always_comb begin
      val_k    = value_q[int'(k_q)*DW +: DW];
      result_d = '0;
      for (int j = 0; j < M; j++) begin
         wgt_k[j]  = weight_q[(j*N + int'(k_q))*DW +: DW];
         prod[j]   = val_k * wgt_k[j];
         mac_d[j]  = acc_q[j] + ACC_W'(prod[j]);
         bias_d[j] = acc_q[j] + (ACC_W'($signed(bias_q[j*DW +: DW])) <<< FRAC);
`ifdef ANN_LAYER_ROUND_EN
         sum[j]    = acc_q[j] + RND_HALF;
`else
         sum[j]    = acc_q[j];
`endif
         shr[j]    = sum[j] >>> FRAC;
         // ReLU clamp wins over saturation only for negative sums, so ordering is harmless
         if (hidden_q && (shr[j] < 0))
            result_d[j*DW +: DW] = '0;
         else if (shr[j] > SAT_MAX)
            result_d[j*DW +: DW] = SAT_MAX[DW-1:0];
         else if (shr[j] < SAT_MIN)
            result_d[j*DW +: DW] = SAT_MIN[DW-1:0];
         else
            result_d[j*DW +: DW] = shr[j][DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         value_q  <= '0;
         weight_q <= '0;
         bias_q   <= '0;
         hidden_q <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int j = 0; j < M; j++) acc_q[j] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  value_q  <= value;
                  weight_q <= weight;
                  bias_q   <= bias;
                  hidden_q <= hidden;
                  k_q      <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= MAC;
                  for (int j = 0; j < M; j++) acc_q[j] <= '0;
               end
            end
            MAC: begin
               for (int j = 0; j < M; j++) acc_q[j] <= mac_d[j];
               if (k_q == KW'(N-1)) begin
                  k_q     <= '0;
                  state_q <= BIAS;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            BIAS: begin
               for (int j = 0; j < M; j++) acc_q[j] <= bias_d[j];
               state_q <= ACT;
            end
            ACT: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_ann_layer.sv
// tb/tb_ann_layer.sv - scoreboard bench for ann_layer (DW=8, N=4, M=2, FRAC=4).
module tb_ann_layer;
   localparam int DW = 8;
   localparam int N = 4;
   localparam int M = 2;
   localparam int FRAC = 4;
   localparam int LAT = N + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              hidden = 1'b0;
   logic [DW*N-1:0]   value = '0;
   logic [DW*N*M-1:0] weight = '0;
   logic [DW*M-1:0]   bias = '0;
   logic [DW*M-1:0]   result;
   logic              busy;
   logic              done;

   int errors = 0;
   int checks = 0;
   logic [DW*M-1:0] exp_q [$];

   ann_layer #(.DW(DW), .N(N), .M(M), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .start(start), .hidden(hidden),
      .value(value), .weight(weight), .bias(bias),
      .result(result), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW*M-1:0] model(input logic [DW*N-1:0] v, input logic [DW*N*M-1:0] w,
                                             input logic [DW*M-1:0] b, input logic h);
      logic [DW*M-1:0] r;
      longint acc, s;
      r = '0;
      for (int j = 0; j < M; j++) begin
         acc = 0;
         for (int i = 0; i < N; i++)
            acc += longint'($signed(v[DW*i +: DW])) * longint'($signed(w[DW*(j*N+i) +: DW]));
         acc += longint'($signed(b[DW*j +: DW])) * (64'sd1 <<< FRAC);
`ifdef ANN_LAYER_ROUND_EN
         acc += (64'sd1 <<< (FRAC-1));
`endif
         s = acc >>> FRAC;
         if (s > 127) s = 127;
         if (s < -128) s = -128;
         if (h && s < 0) s = 0;
         r[DW*j +: DW] = s[DW-1:0];
      end
      return r;
   endfunction

   task automatic start_pass(input logic [DW*N-1:0] v, input logic [DW*N*M-1:0] w,
                             input logic [DW*M-1:0] b, input logic h, input logic [DW*M-1:0] e);
      @(negedge clk);
      value = v; weight = w; bias = b; hidden = h; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b want 1", busy);
      end
   endtask

   task automatic finish_pass(input string tag);
      int lat;
      logic [DW*M-1:0] e;
      lat = 0;
      while (lat < 30 && done !== 1'b1) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d edges", tag, lat);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL %s_latency: got %0d edges want %0d", tag, lat, LAT);
      end
      e = exp_q.pop_front();
      checks++;
      if (result !== e) begin
         errors++;
         $display("FAIL %s_result: got %h want %h", tag, result, e);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_at_done: got %b want 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_basic();
      start_pass({N{8'd16}}, {N*M{8'd16}}, {M{8'd16}}, 1'b0, {M{8'd80}});
      finish_pass("basic80");
      start_pass({N{8'd16}}, {N*M{8'hF0}}, '0, 1'b1, '0);
      finish_pass("relu_neg");
      start_pass({N{8'd16}}, {N*M{8'hF0}}, '0, 1'b0, {M{8'hC0}});
      finish_pass("linear_neg");
   endtask

   task automatic test_saturation();
      start_pass({N{8'd127}}, {N*M{8'd127}}, '0, 1'b0, {M{8'h7F}});
      finish_pass("sat_pos");
      start_pass({N{8'd127}}, {N*M{8'h80}}, '0, 1'b0, {M{8'h80}});
      finish_pass("sat_neg");
   endtask

   task automatic test_rounding();
      logic [DW*N*M-1:0] w;
      w = '0;
      for (int j = 0; j < M; j++) w[DW*(j*N) +: DW] = 8'd8;
`ifdef ANN_LAYER_ROUND_EN
      start_pass({{(N-1){8'd0}}, 8'd1}, w, '0, 1'b0, {M{8'd1}});
`else
      start_pass({{(N-1){8'd0}}, 8'd1}, w, '0, 1'b0, {M{8'd0}});
`endif
      finish_pass("round");
   endtask

   task automatic test_ignore_start();
      int ndone;
      logic [DW*M-1:0] e;
      start_pass({N{8'd16}}, {N*M{8'd16}}, {M{8'd16}}, 1'b0, {M{8'd80}});
      @(negedge clk);
      start = 1'b1; value = {N{8'd127}}; weight = {N*M{8'h80}}; bias = '1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            ndone++;
            e = exp_q.pop_front();
            checks++;
            if (result !== e) begin errors++; $display("FAIL ignore_result: got %h want %h", result, e); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_done: got %b want 0", busy); end
            @(posedge clk);
            #1 c++;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after: got %b want 0", busy); end
         end
      end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
   endtask

   task automatic test_back_to_back();
      logic [DW*N-1:0] v;
      logic [DW*N*M-1:0] w;
      logic [DW*M-1:0] b;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < N; i++) v[DW*i +: DW] = 8'($urandom_range(0, 255));
         for (int i = 0; i < N*M; i++) w[DW*i +: DW] = 8'($urandom_range(0, 255));
         for (int i = 0; i < M; i++) b[DW*i +: DW] = 8'($urandom_range(0, 255));
         start_pass(v, w, b, 1'(p), model(v, w, b, 1'(p)));
         finish_pass("b2b_rand");
      end
   endtask

   task automatic test_reset_midpass();
      int ndone;
      start_pass({N{8'd16}}, {N*M{8'd16}}, {M{8'd16}}, 1'b0, {M{8'd80}});
      finish_pass("pre_abort");
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
      @(negedge clk) rst = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1 if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", ndone); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL abort_result_hold: got %h want 0", result); end
      start_pass({N{8'd16}}, {N*M{8'd16}}, {M{8'd16}}, 1'b0, {M{8'd80}});
      finish_pass("post_abort");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_ignore_start();
      test_back_to_back();
      test_reset_midpass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
endmodule

// File: doc/ann_layer.md
ANN_LAYER -- requirements
Module: ann_layer

Interface
REQ-001 Parameter DW, default 8: signed two's-complement width of value, weight, bias and result words.
REQ-002 Parameter N, default 10: inputs per neuron; MAC cycles per layer pass.
REQ-003 Parameter M, default 4: neurons (output channels) computed in parallel.
REQ-004 Parameter FRAC, default 4: fractional bits of the fixed-point format (Q(DW-FRAC).FRAC); 1 <= FRAC < DW.
REQ-005 Parameter ACC_W, default 2*DW+$clog2(N)+1: signed accumulator width per neuron.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-low.
REQ-008 start  input  1  request a layer pass; sampled only in IDLE.
REQ-009 hidden  input  1  activation mode, latched at start: 1 = ReLU, 0 = linear.
REQ-010 value  input  DW*N  input vector; word i at bits [DW*i +: DW].
REQ-011 weight  input  DW*N*M  weights; neuron j, input i at bits [DW*(j*N+i) +: DW].
REQ-012 bias  input  DW*M  per-neuron bias, same Q format as result.
REQ-013 result  output  DW*M  registered activated outputs; neuron j at [DW*j +: DW].
REQ-014 busy  output  1  high while a pass is in progress.
REQ-015 done  output  1  one-cycle pulse when result updates.

Function
REQ-016 FSM states IDLE, MAC, BIAS, ACT; reset state IDLE.
REQ-017 IDLE: start=1 latches value, weight, bias, hidden into internal registers, clears all M accumulators and input index, -> MAC.
REQ-018 MAC: per cycle, index k (0..N-1), acc[j] += value[k]*weight[j][k] (full 2*DW signed product, sign-extended to ACC_W); after k=N-1 -> BIAS.
REQ-019 BIAS: acc[j] += sign-extended bias[j] << FRAC; -> ACT.
REQ-020 ACT: s[j] = acc[j] >>> FRAC (arithmetic); saturate to [-2^(DW-1), 2^(DW-1)-1]; if hidden latched 1 and s[j] < 0, output 0; register into result; done=1 this cycle; -> IDLE.
REQ-021 Latency: start accepted at edge E; done high and result valid in the cycle after edge E+N+2; next start accepted at edge E+N+3 earliest.
REQ-022 busy = 1 in MAC, BIAS, ACT; 0 in IDLE.
REQ-023 start while busy is ignored; no queuing; inputs changing during a pass have no effect.
REQ-024 result holds its value between passes; changes only in ACT.
REQ-025 Accumulators never wrap for any legal inputs (ACC_W sizing guarantees it).
REQ-026 M and N of 1 are legal; index counter width max(1,$clog2(N)).

Reset
REQ-027 rst=0 at any time, including mid-pass: state IDLE, result all zero, busy 0, done 0, accumulators and index 0, asynchronously.
REQ-028 After rst deasserts, first start is accepted on the first rising edge with start=1.

Configuration
REQ-029 Macro ANN_LAYER_ROUND_EN defined: in ACT, add 2^(FRAC-1) to acc[j] before the shift (round half up); saturation follows rounding.
REQ-030 Macro undefined: plain truncation by arithmetic shift; no rounding adder synthesised.

Verification (DW=8, N=4, M=2, FRAC=4)
REQ-031 All values 16, all weights 16, bias 16, hidden=0 -> done 6 edges after start accept, both results 80.
REQ-032 Values 16, weights -16, bias 0, hidden=1 -> results 0; same with hidden=0 -> results -64.
REQ-033 Values 127, weights 127, bias 0 -> results saturate to 127; weights -128 with hidden=0 -> -128.
REQ-034 value[0]=1, weight[j][0]=8, others 0, bias 0 -> result 0 without ANN_LAYER_ROUND_EN, 1 with it.
REQ-035 start pulsed again during MAC -> ignored, exactly one done pulse, busy low one cycle after done.
REQ-036 rst low for one cycle during MAC -> busy 0, done never pulses, result 0; subsequent pass from REQ-031 yields 80.
